// File: rtl/rv_data_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rv_data_mem
//  Purpose  : RV32 data memory for the MEM stage. The memory is organised as
//             32-bit words and accepts one load or store per cycle through a
//             valid/ready handshake. It supports LB/LH/LW/LBU/LHU and
//             SB/SH/SW, and it flags out-of-range, misaligned and
//             illegal-funct3 requests as faults that have no side effects.
//             After reset a clear sequence writes one word per cycle.
//             BOOT_WORD0 is written to word 0 and every other word is zeroed.
//  Ports    : clk, reset          - clock, synchronous active-high reset
//             req_valid/ready    - request handshake
//             req_write          - 1 = store, 0 = load
//             req_funct3         - RV32 width/extension code
//             req_addr           - byte address
//             req_wdata          - store data (low bits for SB/SH)
//             rsp_valid          - one-cycle response strobe, no backpressure
//             rsp_rdata          - extended load data (0 for stores/faults)
//             rsp_fault          - request was illegal and had no effect
//             busy               - clear sequence in progress
//  Revision : 1.0 - initial release
// ============================================================================
module rv_data_mem #(
    parameter int          DEPTH_WORDS    = 256,
    parameter int          READ_LATENCY   = 1,
    parameter int          CLEAR_ON_RESET = 1,
    parameter logic [31:0] BOOT_WORD0     = 32'h0000_0005
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // One pipe stage. The word is read on the acceptance edge and travels
    // with its metadata, so extraction can happen in the final stage.
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [2:0]  funct3;
        logic [1:0]  lane;
        logic        fault;
        logic [31:0] word;
    } stage_t;

    state_e          state_q;
    logic [AW-1:0]   clr_idx_q;
    logic [31:0]     mem_q [DEPTH_WORDS];
    stage_t          pipe_q [READ_LATENCY];

    logic            w_accept;
    logic [1:0]      w_size;
    logic [1:0]      w_lane;
    logic [AW-1:0]   w_word_idx;
    logic            w_range_ok;
    logic            w_f3_ok;
    logic            w_misalign;
    logic            w_fault;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata_al;
    stage_t          w_stage0;
    stage_t          w_last;
    logic [31:0]     w_shifted;
    logic [31:0]     w_ext;

    // ------------------------------------------------------------------
    // Clear / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            // Without clearing, CLEAR lasts a single cycle.
            if (CLEAR_ON_RESET == 0 || clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                state_q <= ST_RUN;
            end
            clr_idx_q <= clr_idx_q + AW'(1);
        end
    end

    assign req_ready = (state_q == ST_RUN);
    assign busy      = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_accept   = req_valid && req_ready;
    assign w_size     = req_funct3[1:0];
    assign w_lane     = req_addr[1:0];
    assign w_word_idx = req_addr[2 +: AW];
    // Any set bit above the word index places the address beyond the array.
    assign w_range_ok = (req_addr[31:AW+2] == '0);
    assign w_f3_ok    = req_write ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                                  : !(req_funct3 inside {3'b011, 3'b110, 3'b111});
    assign w_misalign = ((w_size == 2'b01) && req_addr[0]) ||
                        ((w_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_fault    = !w_range_ok || !w_f3_ok || w_misalign;

    // Replicating the store data across lanes makes the byte enables
    // the only lane-dependent part of the write.
    always_comb begin
        w_be       = 4'b1111;
        w_wdata_al = req_wdata;
        case (w_size)
            2'b00: begin
                w_be       = 4'b0001 << w_lane;
                w_wdata_al = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be       = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wdata_al = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be       = 4'b1111;
                w_wdata_al = req_wdata;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage: clear writes take precedence because no request can be
    // accepted while the clear is running. Nothing is written in a reset
    // cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                if (CLEAR_ON_RESET != 0) begin
                    mem_q[clr_idx_q] <= (clr_idx_q == '0) ? BOOT_WORD0 : 32'h0;
                end
            end else if (w_accept && req_write && !w_fault) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be[b]) begin
                        mem_q[w_word_idx][8*b +: 8] <= w_wdata_al[8*b +: 8];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline
    // ------------------------------------------------------------------
    always_comb begin
        w_stage0        = '0;
        w_stage0.valid  = w_accept;
        w_stage0.write  = req_write;
        w_stage0.funct3 = req_funct3;
        w_stage0.lane   = w_lane;
        w_stage0.fault  = w_fault;
        w_stage0.word   = mem_q[w_word_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= w_stage0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign w_last    = pipe_q[READ_LATENCY-1];
    // Legal word accesses have lane 0, so the shifted word is usable for
    // LW as well.
    assign w_shifted = w_last.word >> {w_last.lane, 3'b000};

    always_comb begin
        w_ext = w_shifted;
        case (w_last.funct3)
            3'b000:  w_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ext = {24'h0, w_shifted[7:0]};
            3'b101:  w_ext = {16'h0, w_shifted[15:0]};
            default: w_ext = w_shifted;
        endcase
    end

    assign rsp_valid = w_last.valid;
    assign rsp_fault = w_last.valid && w_last.fault;
    assign rsp_rdata = (w_last.valid && !w_last.write && !w_last.fault) ? w_ext : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_rv_data_mem.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rv_data_mem
//  Purpose  : Self-checking bench for rv_data_mem (256 words, 3-cycle read
//             latency, clear on reset). A byte-array reference model predicts
//             every response.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_data_mem;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 3;
    localparam logic [31:0] BOOT  = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic        busy;

    rv_data_mem #(
        .DEPTH_WORDS   (DEPTH),
        .READ_LATENCY  (LAT),
        .CLEAR_ON_RESET(1),
        .BOOT_WORD0    (BOOT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_fault (rsp_fault),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        fault;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    rsp_t       got[$];
    rsp_t       exp_q[$];
    logic [7:0] ref_mem [4*DEPTH];

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) got.push_back('{rsp_fault, rsp_rdata, cyc});
    end

    // Reference model: byte-addressed little-endian memory.
    function automatic void init_model();
        for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 4; i++) ref_mem[i] = 8'(BOOT >> (8*i));
    endfunction

    function automatic void model(input logic w, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] d,
                                  output logic flt, output logic [31:0] rd);
        int          n;
        logic [31:0] v;
        n   = 1 << f3[1:0];
        flt = 1'b0;
        rd  = 32'h0;
        if (a >= 32'(4*DEPTH)) flt = 1'b1;
        if (w && f3 > 3'd2) flt = 1'b1;
        if (!w && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) flt = 1'b1;
        if ((a % 32'(n)) != 0) flt = 1'b1;
        if (flt) return;
        if (w) begin
            for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = 8'(d >> (8*i));
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + 32'(i)]) << (8*i));
            if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
            rd = v;
        end
    endfunction

    // Drive one request at a negedge; it is accepted on the next posedge.
    task automatic send(input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
        logic        flt;
        logic [31:0] rd;
        req_valid  = 1'b1;
        req_write  = w;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        model(w, f3, a, d, flt, rd);
        exp_q.push_back('{flt, rd, cyc + LAT});
        @(negedge clk);
    endtask

    task automatic idle();
        req_valid  = 1'b0;
        req_write  = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = 32'($urandom_range(0, 63));
        req_wdata  = $urandom;
        @(negedge clk);
    endtask

    // Bounded wait for n responses, then a few extra cycles to expose strays.
    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        req_valid = 1'b0;
        while (got.size() < n && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        int r;
        int n;
        bit busy_ok;
        // A store held valid during the clear must never be accepted.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h8;
        req_wdata  = 32'hFFFF_FFFF;
        reset      = 1'b1;
        @(negedge clk);
        r     = cyc;
        reset = 1'b0;
        checks++;
        if ({req_ready, busy, rsp_valid, rsp_fault} !== 4'b0100) begin
            failures++;
            $display("FAIL reset_flags: ready/busy/valid/fault=%b expected 0100",
                     {req_ready, busy, rsp_valid, rsp_fault});
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_rdata: got %h expected 00000000", rsp_rdata);
        end
        init_model();
        got.delete();
        exp_q.delete();
        n       = 0;
        busy_ok = 1'b1;
        while (req_ready !== 1'b1 && n < 2000) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        checks++;
        if (cyc - r != DEPTH) begin
            failures++;
            $display("FAIL clear_length: ready after %0d cycles expected %0d", cyc - r, DEPTH);
        end
        checks++;
        if (!busy_ok) begin
            failures++;
            $display("FAIL busy_during_clear: busy dropped early, expected 1 throughout");
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_clear: got %b expected 0", busy);
        end
        #1;
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL clear_no_rsp: got %0d responses expected 0", got.size());
        end
    endtask

    task automatic test_after_clear();
        logic [31:0] want [3] = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0000};
        got.delete();
        exp_q.delete();
        send(1'b0, 3'b010, 32'h0,   32'h0);
        send(1'b0, 3'b010, 32'h3FC, 32'h0);
        send(1'b0, 3'b010, 32'h8,   32'h0);
        wait_rsp(3);
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL after_clear_count: got %0d expected 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i].rdata !== want[i] || got[i].fault !== 1'b0 || got[i].cyc != exp_q[i].cyc) begin
                failures++;
                $display("FAIL after_clear[%0d]: rdata=%h fault=%b cyc=%0d expected %h 0 %0d",
                         i, got[i].rdata, got[i].fault, got[i].cyc, want[i], exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_store_load();
        logic [31:0] want [6] = '{32'h0, 32'h0, 32'h1234_8078, 32'hFFFF_FF80,
                                  32'h0000_0080, 32'hFFFF_8078};
        got.delete();
        exp_q.delete();
        send(1'b1, 3'b010, 32'h10, 32'h1234_5678);
        send(1'b1, 3'b000, 32'h11, 32'hAAAA_AA80);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        send(1'b0, 3'b000, 32'h11, 32'h0);
        send(1'b0, 3'b100, 32'h11, 32'h0);
        send(1'b0, 3'b001, 32'h10, 32'h0);
        wait_rsp(6);
        checks++;
        if (got.size() != 6) begin
            failures++;
            $display("FAIL store_load_count: got %0d expected 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            checks++;
            if (got[i].rdata !== want[i] || got[i].fault !== 1'b0 || got[i].cyc != exp_q[i].cyc) begin
                failures++;
                $display("FAIL store_load[%0d]: rdata=%h fault=%b cyc=%0d expected %h 0 %0d",
                         i, got[i].rdata, got[i].fault, got[i].cyc, want[i], exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_faults();
        logic        wantf [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] want  [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h1234_8078};
        got.delete();
        exp_q.delete();
        send(1'b1, 3'b001, 32'h13,        32'hFFFF_FFFF);
        send(1'b0, 3'b010, 32'h02,        32'h0);
        send(1'b0, 3'b010, 32'h400,       32'h0);
        send(1'b0, 3'b011, 32'h10,        32'h0);
        send(1'b1, 3'b011, 32'h10,        32'hFFFF_FFFF);
        send(1'b1, 3'b000, 32'h1000_0010, 32'hFFFF_FFFF);
        send(1'b1, 3'b010, 32'h12,        32'hFFFF_FFFF);
        send(1'b0, 3'b010, 32'h10,        32'h0);
        wait_rsp(8);
        checks++;
        if (got.size() != 8) begin
            failures++;
            $display("FAIL faults_count: got %0d expected 8", got.size());
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i].rdata !== want[i] || got[i].fault !== wantf[i] || got[i].cyc != exp_q[i].cyc) begin
                failures++;
                $display("FAIL faults[%0d]: rdata=%h fault=%b cyc=%0d expected %h %b %0d",
                         i, got[i].rdata, got[i].fault, got[i].cyc, want[i], wantf[i], exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int first_ld;
        got.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) send(1'b1, 3'b010, 32'(4*i), $urandom);
        first_ld = cyc + 1;
        for (int i = 0; i < 8; i++) send(1'b0, 3'b010, 32'(4*i), 32'h0);
        wait_rsp(16);
        checks++;
        if (got.size() != 16) begin
            failures++;
            $display("FAIL b2b_count: got %0d expected 16", got.size());
        end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++;
            if (got[i].rdata !== exp_q[i].rdata || got[i].fault !== exp_q[i].fault ||
                got[i].cyc != exp_q[i].cyc) begin
                failures++;
                $display("FAIL b2b[%0d]: rdata=%h fault=%b cyc=%0d expected %h %b %0d",
                         i, got[i].rdata, got[i].fault, got[i].cyc,
                         exp_q[i].rdata, exp_q[i].fault, exp_q[i].cyc);
            end
        end
        checks++;
        if (got.size() == 16 && got[8].cyc != first_ld + LAT - 1) begin
            failures++;
            $display("FAIL b2b_first_latency: first load rsp at %0d expected %0d",
                     got[8].cyc, first_ld + LAT - 1);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        bit          quiet_ok;
        got.delete();
        exp_q.delete();
        quiet_ok = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                case ($urandom_range(0, 9))
                    0:       a = $urandom;
                    1:       a = 32'($urandom_range(1016, 1100));
                    default: a = 32'($urandom_range(0, 63));
                endcase
                send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
            end
            if (rsp_valid !== 1'b1 && (rsp_rdata !== 32'h0 || rsp_fault !== 1'b0)) quiet_ok = 1'b0;
        end
        wait_rsp(exp_q.size());
        checks++;
        if (!quiet_ok) begin
            failures++;
            $display("FAIL random_idle_outputs: rdata/fault nonzero while rsp_valid=0, expected 0");
        end
        checks++;
        if (got.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d expected %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i].rdata !== exp_q[i].rdata || got[i].fault !== exp_q[i].fault ||
                got[i].cyc != exp_q[i].cyc) begin
                failures++;
                $display("FAIL random[%0d]: rdata=%h fault=%b cyc=%0d expected %h %b %0d",
                         i, got[i].rdata, got[i].fault, got[i].cyc,
                         exp_q[i].rdata, exp_q[i].fault, exp_q[i].cyc);
            end
        end
    endtask

    task automatic test_reset_inflight();
        int          r;
        int          n;
        logic [31:0] want [3] = '{32'h0, 32'h0, 32'h0000_0005};
        send(1'b1, 3'b010, 32'h20, 32'hA5A5_A5A5);
        wait_rsp(1);
        got.delete();
        exp_q.delete();
        send(1'b0, 3'b010, 32'h0, 32'h0);
        send(1'b0, 3'b010, 32'h4, 32'h0);
        // Store presented in the same cycle as reset.
        req_valid  = 1'b1;
        req_write  = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h24;
        req_wdata  = 32'hDEAD_BEEF;
        reset      = 1'b1;
        @(negedge clk);
        r         = cyc;
        reset     = 1'b0;
        req_valid = 1'b0;
        checks++;
        if ({req_ready, busy, rsp_valid, rsp_fault} !== 4'b0100 || rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL inflight_reset_state: ready/busy/valid/fault=%b rdata=%h expected 0100 0",
                     {req_ready, busy, rsp_valid, rsp_fault}, rsp_rdata);
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc - r != DEPTH) begin
            failures++;
            $display("FAIL inflight_clear_length: ready after %0d cycles expected %0d", cyc - r, DEPTH);
        end
        #1;
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL inflight_discard: got %0d responses expected 0", got.size());
        end
        init_model();
        got.delete();
        exp_q.delete();
        send(1'b0, 3'b010, 32'h24, 32'h0);
        send(1'b0, 3'b010, 32'h20, 32'h0);
        send(1'b0, 3'b010, 32'h0,  32'h0);
        wait_rsp(3);
        checks++;
        if (got.size() != 3) begin
            failures++;
            $display("FAIL inflight_post_count: got %0d expected 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i].rdata !== want[i] || got[i].fault !== 1'b0 || got[i].cyc != exp_q[i].cyc) begin
                failures++;
                $display("FAIL inflight_post[%0d]: rdata=%h fault=%b cyc=%0d expected %h 0 %0d",
                         i, got[i].rdata, got[i].fault, got[i].cyc, want[i], exp_q[i].cyc);
            end
        end
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        test_reset();
        test_after_clear();
        test_store_load();
        test_faults();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/rv_data_mem.md
# rv_data_mem

Parametrised RV32 data memory for the MEM stage. It is word-organised and accepts one request per cycle through a valid/ready handshake. It supports byte, halfword and word loads and stores, with sign or zero extension, and flags misaligned or out-of-range accesses. It replaces the fixed 1 KiB byte array with a configurable depth, a configurable read latency, and a hardware clear sequence after reset.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words. Must be a power of 2 and at least 2. Valid byte addresses are 0 to 4*DEPTH_WORDS-1.
- READ_LATENCY, 1: cycles from request acceptance to response. Legal values are 1 to 3.
- CLEAR_ON_RESET, 1: when 1, memory is zeroed after reset. When 0, the clear sequence is skipped.
- BOOT_WORD0, 32'h0000_0005: value written to word 0 by the clear sequence.

Ports:
- clk, input, 1: the single clock. All state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- req_valid, input, 1: a request is present.
- req_ready, output, 1: the block can accept a request this cycle.
- req_write, input, 1: 1 means store, 0 means load.
- req_funct3, input, 3: RV32 funct3. Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101. Stores: SB=000, SH=001, SW=010.
- req_addr, input, 32: byte address.
- req_wdata, input, 32: store data. The value to store sits in the low bits for SB and SH.
- rsp_valid, output, 1: single-cycle response strobe. There is no backpressure on responses.
- rsp_rdata, output, 32: extended load data. It is 0 for stores and for faulted requests.
- rsp_fault, output, 1: the request was illegal and had no effect.
- busy, output, 1: the clear sequence is in progress.

## Operation
- FSM states: CLEAR and RUN.
  - reset forces CLEAR and sets clr_idx to 0.
  - In CLEAR, one word is written per cycle. Word clr_idx gets 0, except word 0, which gets BOOT_WORD0.
  - When clr_idx reaches DEPTH_WORDS-1, the FSM moves to RUN on the next edge.
  - If CLEAR_ON_RESET=0, the first cycle after reset goes straight to RUN and memory contents are undefined.
- Signals by state:
  - req_ready = (state==RUN).
  - busy = (state==CLEAR).
- A request is accepted when req_valid && req_ready.
- Word index is req_addr[2+:log2(DEPTH_WORDS)]. Byte lane is req_addr[1:0].
- A request faults, with no memory write, under any of these conditions:
  - req_addr >= 4*DEPTH_WORDS;
  - the funct3 is illegal for its direction (loads: 011, 110, 111; stores: anything other than 000/001/010);
  - halfword access with addr[0]=1;
  - word access with addr[1:0]!=0.
- Store byte enables:
  - SB: lane addr[1:0] gets wdata[7:0].
  - SH: lanes addr[1]*2 and addr[1]*2+1 get wdata[15:0].
  - SW: all four lanes get wdata.
  - Unselected bytes are preserved.
- Loads:
  - The word is read on the acceptance edge.
  - The selected byte or half is shifted down by lane.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Response pipeline:
  - Each accepted request, load or store, travels through a READ_LATENCY-deep pipe carrying valid, write, funct3, lane and fault.
  - Extraction and extension happen in the final stage.
- A store accepted in cycle N is visible to a load accepted in cycle N+1 or later. No forwarding is needed.
- Reset during operation:
  - All in-flight responses are discarded.
  - A store presented in the reset cycle is not performed.
  - Memory is cleared again if CLEAR_ON_RESET=1.

## Timing
- Reset values, in the cycle after reset is sampled high:
  - req_ready=0, busy=CLEAR_ON_RESET, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
  - All pipe valid bits are 0.
- Clear duration: reset is sampled on edge R; req_ready first rises after edge R+DEPTH_WORDS.
- Latency: a request accepted on edge A has rsp_valid high during the cycle after edge A+READ_LATENCY-1, for exactly one cycle.
- Throughput is one request per cycle, with responses in acceptance order.
- rsp_rdata and rsp_fault are valid only while rsp_valid=1. Otherwise they are held at 0.

## Test plan
- Reset with DEPTH_WORDS=256 and CLEAR_ON_RESET=1, then count cycles -> req_ready rises exactly 256 cycles after reset is sampled; busy=1 throughout the clear.
- After clear: LW addr 0 -> rsp_rdata=0x00000005, fault=0. LW addr 0x3FC -> 0x00000000.
- SW 0x12345678 @0x10, then SB 0x80 @0x11 -> a following LW @0x10 returns 0x12348078, LB @0x11 returns 0xFFFFFF80, LBU @0x11 returns 0x00000080, LH @0x10 returns 0xFFFF8078.
- SH @0x13, LW @0x02, LW @0x400 and a load with funct3 011 -> each gets rsp_fault=1 with rdata=0, and memory at 0x10 is unchanged.
- READ_LATENCY=3, eight back-to-back loads from addresses 0x0 to 0x1C -> eight consecutive rsp_valid cycles, in order, starting 3 cycles after the first acceptance.
- Assert reset while 3 responses are in flight -> no rsp_valid until after the clear completes, and the SW issued in the reset cycle is absent on a later LW.
